// File: rtl/sim_run_ctrl_pkg.sv
// sim_ctrl_pkg: shared types, constants and helpers for the simulation run controller
package sim_ctrl_pkg;

    localparam int CNT_W = 64;

    localparam logic [7:0] EXIT_GOOD    = 8'h00;
    localparam logic [7:0] EXIT_TIMEOUT = 8'hFE;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        S_HOLD,
        S_INIT,
        S_RUN,
        S_DUMP,
        S_DRAIN,
        S_DONE
    } sim_state_e;

    // Half-open unsigned window [b, e); an e of 0 makes the window empty
    function automatic logic in_window(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] b,
                                       input logic [CNT_W-1:0] e);
        return (c >= b) && (c < e);
    endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// sim_run_ctrl_if: core UART strobe in, host valid/ready byte stream out
interface sim_run_ctrl_if;
    import sim_ctrl_pkg::*;

    logic  uart_in_valid;
    byte_t uart_in_ch;
    logic  host_valid;
    logic  host_ready;
    byte_t host_ch;

    modport master (
        output uart_in_valid, uart_in_ch, host_ready,
        input  host_valid, host_ch
    );

    modport slave (
        input  uart_in_valid, uart_in_ch, host_ready,
        output host_valid, host_ch
    );

endinterface

// File: rtl/sim_uart_fifo.sv
// sim_uart_fifo: byte FIFO with wrap-bit pointers and a sticky drop flag
module sim_uart_fifo
    import sim_ctrl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  byte_t din,
    output byte_t dout,
    output logic  full,
    output logic  empty,
    output logic  overflow
);
    localparam int AW = $clog2(DEPTH);

    byte_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; a push into a full FIFO only lands if a pop frees the slot this cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem      <= '{default: '0};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: sequences core reset, init pulse, run, perf dump and UART drain for the sim top
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int               RESET_CYCLES = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES   = '0,
    parameter int               UART_DEPTH   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] log_begin,
    input  logic [CNT_W-1:0] log_end,
    input  logic             stop_valid,
    input  byte_t            stop_code,
    sim_run_ctrl_if.slave    uart,
    output logic             core_reset,
    output logic             init_req,
    output logic             log_enable,
    output logic             perf_dump,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             uart_overflow,
    output logic             finish,
    output byte_t            exit_code
);
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    sim_state_e       state;
    logic [HW-1:0]    hold_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;
    logic             push;
    logic             fifo_empty;
    logic             fifo_full_unused;
    byte_t            fifo_dout;

    assign cnt_inc         = cycle_cnt + 1'b1;
    assign timeout         = (MAX_CYCLES != '0) && (cycle_cnt == MAX_CYCLES - 1'b1);
    assign push            = uart.uart_in_valid && !core_reset && (state != S_DONE);
    assign uart.host_valid = !fifo_empty;
    assign uart.host_ch    = fifo_dout;

    sim_uart_fifo #(.DEPTH(UART_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (uart.host_ready),
        .din      (uart.uart_in_ch),
        .dout     (fifo_dout),
        .full     (fifo_full_unused),
        .empty    (fifo_empty),
        .overflow (uart_overflow)
    );

    // Run sequencer; log_enable is computed from the count the next cycle will show so it stays registered
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_HOLD;
            hold_cnt   <= HW'(RESET_CYCLES - 1);
            core_reset <= 1'b1;
            init_req   <= 1'b0;
            perf_dump  <= 1'b0;
            log_enable <= 1'b0;
            cycle_cnt  <= '0;
            exit_code  <= '0;
            finish     <= 1'b0;
        end else begin
            init_req   <= 1'b0;
            perf_dump  <= 1'b0;
            log_enable <= 1'b0;
            case (state)
                S_HOLD:
                    if (hold_cnt == '0) begin
                        state      <= S_INIT;
                        core_reset <= 1'b0;
                        init_req   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                S_INIT: begin
                    state      <= S_RUN;
                    cycle_cnt  <= '0;
                    log_enable <= in_window('0, log_begin, log_end);
                end
                S_RUN:
                    if (stop_valid || timeout) begin
                        state     <= S_DUMP;
                        exit_code <= stop_valid ? stop_code : EXIT_TIMEOUT;
                        perf_dump <= 1'b1;
                    end else begin
                        cycle_cnt  <= cnt_inc;
                        log_enable <= in_window(cnt_inc, log_begin, log_end);
                    end
                S_DUMP:
                    state <= S_DRAIN;
                S_DRAIN:
                    if (fifo_empty) begin
                        state  <= S_DONE;
                        finish <= 1'b1;
                    end
                default:
                    state <= S_DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed scoreboard bench for the run controller
module tb_sim_run_ctrl;
    import sim_ctrl_pkg::*;

    typedef struct {
        logic [7:0]  code;
        logic [63:0] cnt;
    } fin_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] log_begin;
    logic [63:0] log_end;
    logic        stop_valid;
    logic [7:0]  stop_code;
    logic        core_reset;
    logic        init_req;
    logic        log_enable;
    logic        perf_dump;
    logic [63:0] cycle_cnt;
    logic        uart_overflow;
    logic        finish;
    logic [7:0]  exit_code;

    int    checks = 0;
    int    errors = 0;
    byte_t byte_q[$];
    fin_t  fin_q[$];
    fin_t  fin_exp;
    logic  fin_seen = 1'b0;

    sim_run_ctrl_if u_if ();

    sim_run_ctrl #(
        .RESET_CYCLES (4),
        .MAX_CYCLES   (64'd20),
        .UART_DEPTH   (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .log_begin     (log_begin),
        .log_end       (log_end),
        .stop_valid    (stop_valid),
        .stop_code     (stop_code),
        .uart          (u_if),
        .core_reset    (core_reset),
        .init_req      (init_req),
        .log_enable    (log_enable),
        .perf_dump     (perf_dump),
        .cycle_cnt     (cycle_cnt),
        .uart_overflow (uart_overflow),
        .finish        (finish),
        .exit_code     (exit_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset edge, RESET_CYCLES-long hold, one-cycle init, then first RUN cycle with count 0
    task automatic boot();
        reset = 1'b0;
        tick();
        chk("rst_core_reset", core_reset, 1);
        chk("rst_init_req", init_req, 0);
        chk("rst_perf_dump", perf_dump, 0);
        chk("rst_log_enable", log_enable, 0);
        chk("rst_host_valid", u_if.host_valid, 0);
        chk("rst_host_ch", u_if.host_ch, 0);
        chk("rst_overflow", uart_overflow, 0);
        chk("rst_finish", finish, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_exit_code", exit_code, 0);
        reset = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("hold_core_reset", core_reset, 1);
            chk("hold_init_req", init_req, 0);
        end
        tick();
        chk("init_req_high", init_req, 1);
        chk("init_core_reset", core_reset, 0);
        tick();
        chk("init_req_once", init_req, 0);
        chk("run_first_cnt", cycle_cnt, 0);
    endtask

    task automatic wait_finish(input string name);
        int n = 0;
        while (!finish && n < 40) begin
            tick();
            n++;
        end
        chk(name, finish, 1);
    endtask

    // Pops the expected byte on every host handshake
    always @(negedge clock) begin
        if (u_if.host_valid && u_if.host_ready) begin
            if (byte_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL uart_extra: got %0h expected no byte", u_if.host_ch);
            end else begin
                chk("uart_byte", u_if.host_ch, byte_q.pop_front());
            end
        end
    end

    // Pops the expected exit code and frozen count when finish rises
    always @(negedge clock) begin
        if (finish && !fin_seen) begin
            if (fin_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL finish_unexpected: got finish=1 expected 0");
            end else begin
                fin_exp = fin_q.pop_front();
                chk("exit_code", exit_code, fin_exp.code);
                chk("final_cycle_cnt", cycle_cnt, fin_exp.cnt);
            end
        end
        fin_seen <= finish;
    end

    // Directed stimulus
    initial begin
        log_begin           = 64'd5;
        log_end             = 64'd8;
        stop_valid          = 1'b0;
        stop_code           = 8'h00;
        u_if.uart_in_valid  = 1'b0;
        u_if.uart_in_ch     = 8'h00;
        u_if.host_ready     = 1'b0;

        boot();
        for (int i = 0; i < 20; i++) begin
            chk("log_window", log_enable, (i >= 5 && i < 8));
            chk("run_cnt", cycle_cnt, i);
            if (i == 19) fin_q.push_back('{8'hFE, 64'd19});
            tick();
        end
        chk("timeout_perf_dump", perf_dump, 1);
        chk("timeout_log_off", log_enable, 0);
        wait_finish("timeout_finish");

        log_end = 64'd0;
        boot();
        for (int i = 0; i < 10; i++) begin
            chk("log_never", log_enable, 0);
            tick();
        end
        stop_valid = 1'b1;
        stop_code  = 8'h00;
        fin_q.push_back('{8'h00, 64'd10});
        tick();
        stop_valid = 1'b0;
        chk("stop_perf_dump", perf_dump, 1);
        chk("stop_cnt_frozen", cycle_cnt, 10);
        tick();
        chk("stop_perf_once", perf_dump, 0);
        chk("stop_not_done_yet", finish, 0);
        wait_finish("stop_finish");
        stop_valid = 1'b1;
        stop_code  = 8'h77;
        tick();
        stop_valid = 1'b0;
        chk("stop_ignored_done", exit_code, 8'h00);
        chk("done_no_dump", perf_dump, 0);

        boot();
        repeat (19) tick();
        chk("prio_cnt", cycle_cnt, 19);
        stop_valid = 1'b1;
        stop_code  = 8'h03;
        fin_q.push_back('{8'h03, 64'd19});
        tick();
        stop_valid = 1'b0;
        chk("prio_perf_dump", perf_dump, 1);
        wait_finish("prio_finish");

        boot();
        fin_q.push_back('{8'hFE, 64'd19});
        for (int k = 0; k < 17; k++) begin
            u_if.uart_in_valid = 1'b1;
            u_if.uart_in_ch    = 8'h41 + 8'(k);
            if (k < 16) byte_q.push_back(8'h41 + 8'(k));
            tick();
            if (k == 15) chk("full_no_overflow", uart_overflow, 0);
        end
        u_if.uart_in_valid = 1'b0;
        chk("uart_overflow", uart_overflow, 1);
        chk("uart_hold_ch", u_if.host_ch, 8'h41);
        u_if.host_ready = 1'b1;
        wait_finish("uart_finish");
        chk("uart_drained", byte_q.size(), 0);
        u_if.host_ready = 1'b0;

        log_begin = 64'd0;
        log_end   = 64'd0;
        boot();
        for (int k = 0; k < 3; k++) begin
            u_if.uart_in_valid = 1'b1;
            u_if.uart_in_ch    = 8'hA0 + 8'(k);
            tick();
        end
        u_if.uart_in_valid = 1'b0;
        stop_valid         = 1'b1;
        stop_code          = 8'h11;
        tick();
        stop_valid = 1'b0;
        tick();
        tick();
        chk("drain_stuck", finish, 0);
        chk("drain_host_valid", u_if.host_valid, 1);
        chk("drain_host_ch", u_if.host_ch, 8'hA0);
        boot();
        chk("after_rst_empty", u_if.host_valid, 0);
        u_if.host_ready = 1'b1;
        repeat (3) tick();
        chk("after_rst_still_empty", u_if.host_valid, 0);
        chk("fin_q_empty", fin_q.size(), 0);
        chk("byte_q_empty", byte_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above never completes
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Synthesizable run controller for the simulation top. It sequences the core's reset release, the one-shot difftest init request, the run phase and the performance dump on stop. It also gates log output by cycle window and buffers core UART bytes for the host with a valid/ready handshake. It sits between the bench shell and `SimTop`, and replaces the ad-hoc `initial`/`always` sequencing in the shell with cycle-exact RTL.

## Interface
Parameters:
- `RESET_CYCLES`, 16: cycles `core_reset` stays high after `reset` deasserts; must be ≥1.
- `MAX_CYCLES`, 0: run-cycle timeout; 0 disables it.
- `UART_DEPTH`, 16: UART FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clock`  in  1  the only clock
- `reset`  in  1  synchronous, active-low (0 = reset)
- `log_begin`  in  64  first run cycle with logging enabled
- `log_end`  in  64  first run cycle with logging disabled; 0 means logging is never enabled
- `stop_valid`  in  1  core reports end of run
- `stop_code`  in  8  exit code sampled with `stop_valid`
- `uart_in_valid`  in  1  core UART byte strobe
- `uart_in_ch`  in  8  core UART byte
- `host_ready`  in  1  host accepts a UART byte
- `core_reset`  out  1  active-high reset to the core
- `init_req`  out  1  one-cycle init pulse
- `log_enable`  out  1  logging gate
- `perf_dump`  out  1  one-cycle perf dump pulse
- `cycle_cnt`  out  64  run-cycle counter
- `host_valid`  out  1  UART byte available
- `host_ch`  out  8  UART byte
- `uart_overflow`  out  1  sticky byte-drop flag
- `finish`  out  1  sticky end-of-simulation flag
- `exit_code`  out  8  final code, valid while `finish` is 1

## Operation
The controller is a state machine with states HOLD, INIT, RUN, DUMP, DRAIN and DONE.

- **HOLD.** This is the state after reset. A down-counter is loaded with `RESET_CYCLES-1` and `core_reset` is 1. When the counter reaches 0, go to INIT.
- **INIT.** `core_reset` is 0 and `init_req` is 1 for exactly one cycle. Go to RUN.
- **RUN.**
  - `cycle_cnt` increments every cycle, starting at 0 on the first RUN cycle.
  - If `stop_valid` is 1, latch `stop_code` into `exit_code` and go to DUMP.
  - Otherwise, if `MAX_CYCLES` is nonzero and `cycle_cnt` equals `MAX_CYCLES-1`, latch 8'hFE and go to DUMP.
  - If both events occur in the same cycle, `stop_valid` wins.
- **DUMP.** `perf_dump` is 1 for one cycle. Go to DRAIN.
- **DRAIN.** Stay until the FIFO is empty and no host handshake is pending, then go to DONE.
- **DONE.** `finish` is 1. The state is terminal until reset.

`stop_valid` is ignored outside RUN.

Logging gate:
- `log_enable` = (state==RUN) && (`cycle_cnt` ≥ `log_begin`) && (`cycle_cnt` < `log_end`).
- All comparisons are unsigned 64-bit.
- `cycle_cnt` wraps modulo 2^64 with no special handling.

UART FIFO:
- A push is `uart_in_valid` while `core_reset` is 0, in any state from INIT through DRAIN.
- A pop is `host_valid && host_ready`.
- Push when full, with no simultaneous pop: the byte is dropped and `uart_overflow` is set.
- Push and pop in the same cycle when full: both succeed and no overflow is flagged.
- Push and pop in the same cycle when empty: the push is stored; there is no bypass.
- Bytes leave in arrival order.
- `host_ch` holds its value while `host_valid` is 1 and `host_ready` is 0.

Reset values (`reset`=0), all registered:
- `core_reset`=1.
- `init_req`, `perf_dump`, `log_enable`, `host_valid`, `uart_overflow`, `finish` = 0.
- `cycle_cnt`=0, `exit_code`=0, `host_ch`=0.
- The FIFO is empty.

Reset asserted in any state, including mid-DRAIN, discards FIFO contents and returns to HOLD on the next edge.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `core_reset` is high for exactly `RESET_CYCLES` cycles after the first cycle with `reset`=1.
- `init_req` is high in the cycle immediately after `core_reset` falls.
- Stop latency: `stop_valid` sampled high at edge N gives `perf_dump`=1 during cycle N+1. `finish` rises no earlier than N+2.
- FIFO latency: a byte pushed at edge N appears on `host_valid`/`host_ch` at N+1 at the earliest.
- Throughput is one byte per cycle each way.
- `cycle_cnt` freezes on leaving RUN.

## Structure
- Package `sim_ctrl_pkg`:
  - state enum `sim_state_e`;
  - exit-code constants `EXIT_GOOD`=8'h00 and `EXIT_TIMEOUT`=8'hFE;
  - `CNT_W`=64.
- Sub-module `sim_uart_fifo`:
  - parameterized by `DEPTH`, with data width 8;
  - outputs full, empty and overflow;
  - contains a pointer-plus-wrap-bit register array.
- The FSM, counters and logging compare live in `sim_run_ctrl`.

## Test plan
- **Reset sequence:** `RESET_CYCLES`=4, release `reset` at edge 0. Require `core_reset`=1 for edges 0–3, `init_req`=1 only at edge 4, and `cycle_cnt`=0 on the first RUN cycle.
- **Good stop:** `stop_valid`=1 with `stop_code`=8'h00 at `cycle_cnt`=10. Require a single `perf_dump` pulse the next cycle, then `finish`=1 with `exit_code`=8'h00, and `cycle_cnt` frozen at 10.
- **Log window:** `log_begin`=5, `log_end`=8. Require `log_enable` high only while `cycle_cnt` is 5, 6 or 7. Repeat with `log_end`=0 and require `log_enable` never high.
- **UART overflow:** `UART_DEPTH`=16, `host_ready`=0, push 17 bytes 8'h41..8'h51. Require `uart_overflow`=1. Then raise `host_ready` and require exactly 8'h41..8'h50 in order.
- **Timeout priority:** `MAX_CYCLES`=20.
  - With no stop, require `exit_code`=8'hFE.
  - With `stop_valid` and `stop_code`=8'h03 in the same cycle as the timeout, require `exit_code`=8'h03.
- **Reset mid-DRAIN:** hold `host_ready`=0 with 3 bytes queued in DRAIN, then pulse `reset`=0. Require every output at its reset value next cycle, an empty FIFO, and a full HOLD→INIT sequence afterwards.
